// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: takes tagged ALU commands and holds each one in a one-entry issue stage that
// drives an external combinational ALU. The ALU result, or an error for an unsupported opcode, is
// captured together with the command tag into a response FIFO. Responses leave in the order the
// commands were accepted.
//
// Parameters:
//   DEPTH  response FIFO entries (power of two, 2..16)
//   TAG_W  command tag width
//
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   cmd_valid/cmd_ready             command handshake
//   cmd_a, cmd_b, cmd_op, cmd_tag   command payload (op 000 = ADD, 011 = LT)
//   alu_a, alu_b, alu_opcode        operands and opcode to the ALU, zero while the stage is empty
//   alu_result                      combinational ALU result
//   rsp_valid/rsp_ready             response handshake
//   rsp_data, rsp_tag, rsp_err      FIFO head; rsp_err flags an unsupported opcode
//   issued_cnt                      count of accepted commands, wraps at 16 bits
//
// Build option: define ALU_CMD_LT_EN to support LT (3'b011). Without it LT returns an error.

module alu_cmd_issuer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_a,
    input  logic [31:0]      cmd_b,
    input  logic [2:0]       cmd_op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [31:0]      alu_result,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_err,
    output logic [15:0]      issued_cnt
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = PtrW + 1;
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [2:0] OpAdd = 3'b000;
`ifdef ALU_CMD_LT_EN
    localparam logic [2:0] OpLt = 3'b011;
`endif

    // Issue stage
    logic             stage_valid_q;
    logic [31:0]      stage_a_q;
    logic [31:0]      stage_b_q;
    logic [2:0]       stage_op_q;
    logic [TAG_W-1:0] stage_tag_q;

    // Response FIFO
    logic [31:0]      fifo_data_q [DEPTH];
    logic [TAG_W-1:0] fifo_tag_q  [DEPTH];
    logic             fifo_err_q  [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  fifo_count_q;

    logic [15:0]      issued_cnt_q;

    logic             push;
    logic             pop;
    logic             accept;
    logic             op_supported;
    logic [31:0]      push_data;

    always_comb begin
        op_supported = (stage_op_q == OpAdd);
`ifdef ALU_CMD_LT_EN
        if (stage_op_q == OpLt) begin
            op_supported = 1'b1;
        end
`endif
    end

    assign rsp_valid = (fifo_count_q != '0);
    assign pop       = rsp_valid && rsp_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still takes the staged command.
    assign push      = stage_valid_q && ((fifo_count_q < FullCnt) || pop);
    assign cmd_ready = !stage_valid_q || push;
    assign accept    = cmd_valid && cmd_ready;
    assign push_data = op_supported ? alu_result : 32'h0;

    assign alu_a      = stage_valid_q ? stage_a_q  : 32'h0;
    assign alu_b      = stage_valid_q ? stage_b_q  : 32'h0;
    assign alu_opcode = stage_valid_q ? stage_op_q : 3'b000;

    // FIFO storage is not reset; the head is masked to zero whenever the FIFO is empty.
    assign rsp_data = rsp_valid ? fifo_data_q[rd_ptr_q] : 32'h0;
    assign rsp_tag  = rsp_valid ? fifo_tag_q[rd_ptr_q]  : '0;
    assign rsp_err  = rsp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

    assign issued_cnt = issued_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage_valid_q <= 1'b0;
            stage_a_q     <= 32'h0;
            stage_b_q     <= 32'h0;
            stage_op_q    <= 3'b000;
            stage_tag_q   <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            issued_cnt_q  <= 16'h0;
        end else begin
            if (accept) begin
                stage_valid_q <= 1'b1;
                stage_a_q     <= cmd_a;
                stage_b_q     <= cmd_b;
                stage_op_q    <= cmd_op;
                stage_tag_q   <= cmd_tag;
                issued_cnt_q  <= issued_cnt_q + 16'd1;
            end else if (push) begin
                stage_valid_q <= 1'b0;
            end

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end

            unique case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + CntW'(1);
                2'b01:   fifo_count_q <= fifo_count_q - CntW'(1);
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= push_data;
            fifo_tag_q[wr_ptr_q]  <= stage_tag_q;
            fifo_err_q[wr_ptr_q]  <= !op_supported;
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
module tb_alu_cmd_issuer;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [2:0]       cmd_op;
    logic [TAG_W-1:0] cmd_tag;
    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_opcode;
    logic [31:0]      alu_result;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_data;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;
    logic [15:0]      issued_cnt;

    alu_cmd_issuer #(
        .DEPTH(DEPTH),
        .TAG_W(TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_op    (cmd_op),
        .cmd_tag   (cmd_tag),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_opcode(alu_opcode),
        .alu_result(alu_result),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .rsp_err   (rsp_err),
        .issued_cnt(issued_cnt)
    );

    always #5 clk = ~clk;

    // External ALU; unsupported codes return a junk value that must never reach a response.
    always_comb begin
        case (alu_opcode)
            3'b000:  alu_result = alu_a + alu_b;
            3'b011:  alu_result = {31'h0, (alu_a < alu_b)};
            default: alu_result = alu_a ^ alu_b ^ 32'hDEAD_BEEF;
        endcase
    end

    typedef struct packed {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } rsp_t;

    // Reference model: responses owed, in acceptance order.
    rsp_t        exp_q[$];
    logic [15:0] exp_issued = 16'h0;
    bit          acc_last   = 1'b0;
    bit          last_acc   = 1'b0;
    int          n_acc      = 0;
    int          checks     = 0;
    int          errors     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rsp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [2:0] op, input logic [TAG_W-1:0] tag);
        rsp_t r;
        r.tag  = tag;
        r.data = 32'h0;
        r.err  = 1'b1;
        if (op == 3'b000) begin
            r.data = a + b;
            r.err  = 1'b0;
        end
`ifdef ALU_CMD_LT_EN
        else if (op == 3'b011) begin
            r.data = (a < b) ? 32'h1 : 32'h0;
            r.err  = 1'b0;
        end
`endif
        return r;
    endfunction

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op, input logic [TAG_W-1:0] tag);
        cmd_valid = v;
        cmd_a     = a;
        cmd_b     = b;
        cmd_op    = op;
        cmd_tag   = tag;
    endtask

    // One clock: check outputs at the falling edge, update the model at the rising edge.
    task automatic tick();
        bit   acc;
        bit   pop;
        bit   exp_valid;
        bit   exp_ready;
        rsp_t got;
        acc = 1'b0;
        pop = 1'b0;
        @(negedge clk);
        if (rst_n === 1'b1) begin
            // The stage holds one command; it is empty only if nothing was accepted last cycle.
            exp_valid = (exp_q.size() >= 2) || (exp_q.size() == 1 && !acc_last);
            exp_ready = (exp_q.size() != DEPTH + 1) || (rsp_ready && exp_valid);
            chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
            chk("cmd_ready", 32'(cmd_ready), 32'(exp_ready));
            chk("issued_cnt", 32'(issued_cnt), 32'(exp_issued));
            if (rsp_valid === 1'b1) begin
                chk("rsp_owed", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    got = exp_q[0];
                    chk("rsp_data", rsp_data, got.data);
                    chk("rsp_tag", 32'(rsp_tag), 32'(got.tag));
                    chk("rsp_err", 32'(rsp_err), 32'(got.err));
                end
            end
            acc = (cmd_valid === 1'b1) && (cmd_ready === 1'b1);
            pop = (rsp_valid === 1'b1) && (rsp_ready === 1'b1);
        end
        @(posedge clk);
        if (rst_n !== 1'b1) begin
            exp_q.delete();
            exp_issued = 16'h0;
            acc = 1'b0;
        end else begin
            if (pop && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
            end
            if (acc) begin
                exp_q.push_back(model(cmd_a, cmd_b, cmd_op, cmd_tag));
                exp_issued = exp_issued + 16'd1;
            end
        end
        acc_last = acc;
        last_acc = acc;
        if (acc) n_acc++;
        #1;
    endtask

    task automatic drain();
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            tick();
        end
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        int base;
        int idx;
        logic [2:0] rop;

        // Reset with a command offered: it must be ignored.
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        drive(1'b1, 32'h11, 32'h22, 3'b000, 4'h5);
        tick();
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_data", rsp_data, 32'h0);
        chk("rst_rsp_tag", 32'(rsp_tag), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_alu_a", alu_a, 32'h0);
        chk("rst_alu_b", alu_b, 32'h0);
        chk("rst_alu_op", 32'(alu_opcode), 32'h0);
        chk("rst_issued", 32'(issued_cnt), 32'h0);

        // ADD: accepted in N, on the ALU in N+1, response in N+2.
        drive(1'b1, 32'h5, 32'h3, 3'b000, 4'h2);
        tick();
        chk("add_accepted", 32'(last_acc), 32'h1);
        drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0);
        chk("add_alu_a", alu_a, 32'h5);
        chk("add_alu_b", alu_b, 32'h3);
        chk("add_alu_op", 32'(alu_opcode), 32'h0);
        chk("add_n1_no_rsp", 32'(rsp_valid), 32'h0);
        tick();
        chk("add_n2_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("add_data", rsp_data, 32'h8);
        chk("add_tag", 32'(rsp_tag), 32'h2);
        chk("add_err", 32'(rsp_err), 32'h0);
        tick();

        // LT
        drive(1'b1, 32'h1, 32'h2, 3'b011, 4'h3);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0);
        chk("lt_alu_op", 32'(alu_opcode), 32'h3);
        tick();
`ifdef ALU_CMD_LT_EN
        chk("lt_data", rsp_data, 32'h1);
        chk("lt_err", 32'(rsp_err), 32'h0);
`else
        chk("lt_data", rsp_data, 32'h0);
        chk("lt_err", 32'(rsp_err), 32'h1);
`endif
        tick();

        // Unsupported op, then a normal command right behind it.
        drive(1'b1, 32'h1234, 32'h4321, 3'b101, 4'h7);
        tick();
        drive(1'b1, 32'd10, 32'd20, 3'b000, 4'h1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0);
        chk("bad_data", rsp_data, 32'h0);
        chk("bad_tag", 32'(rsp_tag), 32'h7);
        chk("bad_err", 32'(rsp_err), 32'h1);
        tick();
        chk("next_data", rsp_data, 32'd30);
        chk("next_tag", 32'(rsp_tag), 32'h1);
        chk("next_err", 32'(rsp_err), 32'h0);
        drain();

        // Back-pressure: 4 in the FIFO plus 1 in the stage, then stall.
        rsp_ready = 1'b0;
        base = n_acc;
        idx  = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, 32'(idx * 3), 32'(idx + 100), 3'b000, 4'(idx + 1));
            tick();
            if (last_acc) idx++;
        end
        chk("bp_accepted", 32'(n_acc - base), 32'd5);
        chk("bp_ready_low", 32'(cmd_ready), 32'h0);
        chk("bp_head_tag", 32'(rsp_tag), 32'h1);

        // Full with a pop in the same cycle: the stage drains and takes a new command.
        rsp_ready = 1'b1;
        #1;
        chk("full_pop_ready", 32'(cmd_ready), 32'h1);
        tick();
        chk("full_pop_accept", 32'(last_acc), 32'h1);
        idx++;
        rsp_ready = 1'b0;
        drive(1'b1, 32'h77, 32'h1, 3'b000, 4'hE);
        #1;
        chk("still_full", 32'(cmd_ready), 32'h0);
        chk("still_valid", 32'(rsp_valid), 32'h1);
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
        end
        drain();

        // Reset mid-stream with three responses queued.
        rsp_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 32'(c), 32'h10, 3'b000, 4'(c + 9));
            tick();
        end
        drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0);
        tick();
        tick();
        chk("pre_rst_valid", 32'(rsp_valid), 32'h1);
        rst_n = 1'b0;
        drive(1'b1, 32'h99, 32'h1, 3'b000, 4'hF);
        tick();
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 3'b000, 4'h0);
        #1;
        chk("mid_rst_valid", 32'(rsp_valid), 32'h0);
        chk("mid_rst_issued", 32'(issued_cnt), 32'h0);
        chk("mid_rst_alu_op", 32'(alu_opcode), 32'h0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            case ($urandom_range(0, 3))
                0:       rop = 3'b011;
                1:       rop = 3'($urandom);
                default: rop = 3'b000;
            endcase
            drive(1'($urandom_range(0, 3) != 0), $urandom, $urandom, rop, 4'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                cmd_a = 32'($urandom_range(0, 7));
                cmd_b = 32'($urandom_range(0, 7));
            end
            rsp_ready = 1'($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning response FIFO entries (power of two, 2..16).
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning command tag width in bits.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 Port cmd_valid, input, 1 bit: command offered.
REQ-006 Port cmd_ready, output, 1 bit: command accepted when high with cmd_valid.
REQ-007 Ports cmd_a and cmd_b, input, 32 bits each: operands.
REQ-008 Port cmd_op, input, 3 bits: opcode; 3'b000 is ADD and 3'b011 is LT, with every other code unsupported.
REQ-009 Port cmd_tag, input, TAG_W bits: caller tag, returned unchanged.
REQ-010 Ports alu_a and alu_b, output, 32 bits each: operands to the combinational ALU.
REQ-011 Port alu_opcode, output, 3 bits: opcode to the ALU.
REQ-012 Port alu_result, input, 32 bits: combinational ALU result for the current alu_a, alu_b and alu_opcode.
REQ-013 Port rsp_valid, output, 1 bit: response available.
REQ-014 Port rsp_ready, input, 1 bit: response consumed when high with rsp_valid.
REQ-015 Port rsp_data, output, 32 bits: result.
REQ-016 Port rsp_tag, output, TAG_W bits: tag of the response.
REQ-017 Port rsp_err, output, 1 bit: unsupported opcode.
REQ-018 Port issued_cnt, output, 16 bits: count of accepted commands; it SHALL wrap from 16'hFFFF to 0.

Function
REQ-019 The block SHALL use a one-entry issue register (stage_valid, a, b, op, tag) to drive alu_a, alu_b and alu_opcode directly.
REQ-020 When stage_valid=0, alu_a, alu_b and alu_opcode SHALL all be 0.
REQ-021 push SHALL be stage_valid && (fifo_count<DEPTH || (rsp_valid && rsp_ready)).
REQ-022 cmd_ready SHALL be !stage_valid || push, so a command is accepted in the same cycle the stage drains.
REQ-023 On accept, the stage SHALL load the command; otherwise, on push, stage_valid SHALL clear.
REQ-024 On push, the FIFO SHALL write {alu_result, tag, err=0} for a supported op, or {32'h0, tag, err=1} for an unsupported op.
REQ-025 Latency: a command accepted in cycle N SHALL be driven to the ALU in cycle N+1 and SHALL give rsp_valid in cycle N+2 when no back-pressure is present.
REQ-026 Sustained throughput SHALL be one command per cycle while rsp_ready=1.
REQ-027 rsp_valid SHALL be fifo_count!=0, and rsp_data, rsp_tag and rsp_err SHALL come from the FIFO head.
REQ-028 Response order SHALL equal command acceptance order.
REQ-029 While rsp_valid=1 and rsp_ready=0, the head SHALL hold stable.
REQ-030 FIFO full with no pop: push=0, the stage SHALL hold, and the ALU outputs SHALL remain stable.
REQ-031 FIFO full with a pop in the same cycle: the push SHALL occur and fifo_count SHALL stay DEPTH.
REQ-032 FIFO empty: a pop is impossible; push then SHALL make fifo_count 1.
REQ-033 FIFO read and write pointers SHALL wrap modulo DEPTH.
REQ-034 issued_cnt SHALL increment by 1 on each cmd_valid && cmd_ready.

Reset
REQ-035 While rst_n=0 at a clk edge, the block SHALL clear stage_valid, fifo_count, both FIFO pointers and issued_cnt.
REQ-036 Reset values: cmd_ready=1 one cycle after release, rsp_valid=0, rsp_data=0, rsp_tag=0, rsp_err=0, alu_a=0, alu_b=0, alu_opcode=0, issued_cnt=0.
REQ-037 Reset mid-operation SHALL discard staged and queued commands, and no response for them SHALL ever appear.
REQ-038 cmd_valid SHALL be ignored during reset.

Configuration
REQ-039 The block SHALL provide the macro ALU_CMD_LT_EN.
REQ-040 With ALU_CMD_LT_EN defined, 3'b011 SHALL be supported and its result taken from alu_result.
REQ-041 Without ALU_CMD_LT_EN, 3'b011 SHALL be unsupported: rsp_err=1, rsp_data=0, with alu_opcode still driven as 3'b011.

Verification
REQ-042 Bench scenario, ADD: A=32'h0000_0005, B=32'h0000_0003, op=000, tag=2, accepted cycle N -> rsp_valid in N+2, data 32'h8, tag 2, err 0.
REQ-043 Bench scenario, LT with macro defined: A=1, B=2, op=011 -> data 32'h1, err 0. Without the macro -> data 0, err 1.
REQ-044 Bench scenario, unsupported op: op=3'b101, tag=7 -> data 0, tag 7, err 1, and the next command is still processed normally.
REQ-045 Bench scenario, back-pressure: rsp_ready=0 and 6 commands with DEPTH=4 -> exactly 5 accepted (4 FIFO + 1 stage), then cmd_ready=0. Raising rsp_ready -> all 5 responses in order with tags intact, and one accept per pop.
REQ-046 Bench scenario, full plus simultaneous pop: FIFO full, stage valid, rsp_ready=1 -> push and pop in the same cycle, fifo_count stays 4, and the stage accepts a new command.
REQ-047 Bench scenario, reset mid-stream: rst_n=0 for 1 cycle with 3 responses queued -> rsp_valid=0 and issued_cnt=0 next cycle, and no stale response afterwards.
